// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: load-use stalls, branch flushes, memory holds, HALT drain.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module pipeline_hazard_sequencer #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_halt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_hold,
`ifdef SEQ_PERF_CNT_EN
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
`else
    output logic                  halted
`endif
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            mem_hold;
    logic            load_use;
    logic            branch_flush;
    logic            halt_accept;

    assign mem_hold = mem_req & ~mem_ready;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Priority in RUN: memory hold > taken branch > load-use > halt.
    assign branch_flush = (state == ST_RUN) && !mem_hold && ex_branch_taken;
    assign halt_accept  = (state == ST_RUN) && !mem_hold && !ex_branch_taken &&
                          !load_use && id_halt;

    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        halted     = 1'b0;
        if (reset) begin
            unique case (state)
                ST_RUN: begin
                    if (mem_hold) begin
                        pipe_hold = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use || id_halt) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idex_flush = 1'b1;
                    pipe_hold  = mem_hold;
                end
                ST_HALTED: begin
                    pipe_hold = 1'b1;
                    halted    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (halt_accept) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (!mem_hold) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DW'(1))
                            state <= ST_HALTED;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((state != ST_HALTED) && !pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (branch_flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush/halt sequencer for the 5-stage RISC-V pipeline.
- Takes hazard information from the ID, EX and MEM stages and drives the PC and pipeline-register write enables and flushes.
- Detects load-use hazards, flushes on taken branches and freezes the pipe during slow data-memory accesses.
- On a HALT opcode, drains the in-flight instructions and then parks the core.

Parameters:
- REG_ADDR_W, 5, register-index width.
- DRAIN_CYCLES, 3, non-held cycles spent draining EX/MEM/WB after HALT is seen in ID; legal range ≥1.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_halt  in  1  Halt decode of the instruction in ID.
- ex_mem_read  in  1  MemRead of the instruction in EX.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  load/store present in MEM.
- mem_ready  in  1  data memory completes the MEM access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_flush  out  1  load a bubble (all controls 0) into ID/EX on the next edge.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- halted  out  1  core parked.

Behaviour:
- Reset and timing:
  - While reset=0, all outputs are forced to 0 regardless of inputs.
  - Asserting reset mid-operation clears the state to RUN and the drain counter to 0 immediately.
  - All outputs are combinational from the registered state plus the current inputs: zero-latency decisions.
- States: RUN, DRAIN, HALTED.
- Default outputs in RUN: pc_write=1, ifid_write=1, flushes=0, pipe_hold=0, halted=0.
- mem_hold = mem_req & ~mem_ready.
- RUN, in priority order:
  1. mem_hold: pc_write=0, ifid_write=0, pipe_hold=1, flushes=0; remain in RUN. All other conditions are ignored this cycle.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_write=1 (PC loads the target). A halt in ID is on the wrong path and is discarded; remain in RUN.
  3. Load-use: ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
     - pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle.
     - ex_rd==0 never stalls.
     - id_halt waits behind the stall.
  4. id_halt: pc_write=0, ifid_write=0, idex_flush=1 (the halt itself becomes a bubble); load the drain counter with DRAIN_CYCLES; go to DRAIN.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1 every cycle.
  - ex_branch_taken, id_halt and load-use are ignored.
  - If mem_hold: additionally pipe_hold=1, and the counter does not decrement.
  - Otherwise the counter decrements. When the counter reaches 0 after a decrement, go to HALTED.
  - DRAIN therefore lasts exactly DRAIN_CYCLES non-held cycles.
- HALTED:
  - pc_write=0, ifid_write=0, pipe_hold=1, halted=1, flushes=0.
  - Exit only via reset.
- Simultaneous events:
  - mem_hold with ex_branch_taken: the hold wins; the branch is re-presented next cycle because EX is frozen.
  - ex_branch_taken with load-use: the branch wins, and the ID instruction is flushed anyway.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined, two extra output ports are added and both reset to 0:
  - stall_cycles [CNT_W]: counts cycles in RUN or DRAIN with pc_write=0.
  - flush_count [CNT_W]: counts branch flushes (priority 2 taken).
  - Both counters saturate at all-ones.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset released, all inputs 0 → pc_write=1, ifid_write=1, other outputs 0. Assert reset mid-DRAIN → all outputs 0 at once; RUN after release.
- ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle → pc_write=0, ifid_write=0, idex_flush=1 that cycle only. Repeat with ex_rd=0, id_rs1=0 → no stall.
- ex_branch_taken=1 with id_halt=1 → ifid_flush=1, idex_flush=1, pc_write=1; no DRAIN, and halted never rises.
- id_halt=1 pulse, DRAIN_CYCLES=3, mem_ready=1 → idex_flush=1 for 4 cycles (entry cycle + 3 drain), then halted=1 and pipe_hold=1, held indefinitely.
- Same as the halt test, but mem_req=1 / mem_ready=0 for 2 cycles during DRAIN → pipe_hold=1 those cycles; halted rises 2 cycles later than in the halt test.
- With SEQ_PERF_CNT_EN: one load-use stall + 2 mem-hold cycles + 1 branch flush → stall_cycles=3, flush_count=1.
